// File: rtl/record_ingress_stamper_if.sv
// record_ingress_stamper_if
//   Record stream from the ingress stamper to event_record_unpack.
//   One beat carries one complete record.
//   Signals:
//     tdata  - record bytes; byte i sits at [8i+7:8i]
//     tuser  - timestamp of the record's first byte
//     tvalid - record available
//     tready - downstream accept
//     tlast  - always equal to tvalid
//   Modports: master (record producer), slave (record consumer).
interface record_ingress_stamper_if #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned TS_W   = 64
);
  logic [DATA_W-1:0] tdata;
  logic [TS_W-1:0]   tuser;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tuser, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tuser, input tvalid, input tlast, output tready);
endinterface

// File: rtl/record_ingress_stamper.sv
// record_ingress_stamper
//   Frames the UART RX byte stream into fixed-size records. Each record is
//   stamped with pl_now from the cycle its first byte arrived. Completed
//   records are queued in a small FIFO, so the downstream stage can apply
//   backpressure. A record that arrives while the FIFO is full is dropped
//   whole. Drops and gap-timeout resyncs are counted with saturating
//   counters.
//   Optional feature: define RECORD_GAP_TIMEOUT_EN to build the inter-byte
//   gap timer. Without it, a partial record waits indefinitely and
//   resync_count is held at 0.
//   Ports:
//     clk, rst_n    - clock; asynchronous active-low reset
//     uart_rx_valid - one-cycle byte strobe (never back-pressured)
//     uart_rx_data  - received byte
//     pl_now        - free-running PL timestamp
//     m_axis        - record stream (master modport)
//     drop_count    - records lost to a full FIFO (saturating)
//     resync_count  - partial records aborted by gap timeout (saturating)
//     fifo_level    - number of stored records
module record_ingress_stamper #(
  parameter int unsigned RECORD_BYTES = 32,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned TS_W         = 64,
  parameter int unsigned GAP_TIMEOUT  = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          uart_rx_valid,
  input  logic [7:0]                    uart_rx_data,
  input  logic [TS_W-1:0]               pl_now,
  record_ingress_stamper_if.master      m_axis,
  output logic [31:0]                   drop_count,
  output logic [31:0]                   resync_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int unsigned DATA_W = RECORD_BYTES * 8;
  localparam int unsigned CNT_W  = $clog2(RECORD_BYTES);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);

  if (RECORD_BYTES < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      GAP_TIMEOUT < 1) begin : g_bad_params
    $error("record_ingress_stamper: illegal parameter combination");
  end

  typedef enum logic {ST_IDLE, ST_COLLECT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  rec_q, rec_d, rec_full;
  logic [TS_W-1:0]    stamp_q, stamp_d;
  logic               push;

  logic [DATA_W-1:0]  mem_data_q [FIFO_DEPTH];
  logic [TS_W-1:0]    mem_ts_q   [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [PTR_W:0]     level_q, level_d;
  logic [31:0]        drop_q, drop_d;
  logic               pop, full, push_ok;

`ifdef RECORD_GAP_TIMEOUT_EN
  localparam int unsigned GAP_W = $clog2(GAP_TIMEOUT + 1);
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [31:0]        resync_q, resync_d;
  logic               resync_inc;
`endif

  // Framer: the last byte is merged combinationally, so the complete record
  // is pushed on the same edge that samples its final byte.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rec_d    = rec_q;
    stamp_d  = stamp_q;
    push     = 1'b0;
    rec_full = rec_q;
    rec_full[{cnt_q, 3'b000} +: 8] = uart_rx_data;
`ifdef RECORD_GAP_TIMEOUT_EN
    gap_d      = gap_q;
    resync_inc = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef RECORD_GAP_TIMEOUT_EN
        gap_d = '0;
`endif
        if (uart_rx_valid) begin
          rec_d[7:0] = uart_rx_data;
          stamp_d    = pl_now;
          cnt_d      = CNT_W'(1);
          state_d    = ST_COLLECT;
        end
      end
      default: begin
        if (uart_rx_valid) begin
`ifdef RECORD_GAP_TIMEOUT_EN
          gap_d = '0;
`endif
          if (cnt_q == CNT_W'(RECORD_BYTES - 1)) begin
            push    = 1'b1;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            rec_d = rec_full;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`ifdef RECORD_GAP_TIMEOUT_EN
        // A byte on the timeout cycle takes the branch above, so it is kept.
        else if (gap_q == GAP_W'(GAP_TIMEOUT - 1)) begin
          gap_d      = '0;
          cnt_d      = '0;
          state_d    = ST_IDLE;
          resync_inc = 1'b1;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
`endif
      end
    endcase
  end

  // Record FIFO. When full, a push is still accepted if the head is popped
  // on the same cycle; it then writes into the slot being vacated.
  always_comb begin
    pop     = m_axis.tvalid && m_axis.tready;
    full    = (level_q == (PTR_W + 1)'(FIFO_DEPTH));
    push_ok = push && (!full || pop);
    wr_d    = push_ok ? wr_q + PTR_W'(1) : wr_q;
    rd_d    = pop ? rd_q + PTR_W'(1) : rd_q;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + (PTR_W + 1)'(1);
      2'b01:   level_d = level_q - (PTR_W + 1)'(1);
      default: level_d = level_q;
    endcase
    drop_d = drop_q;
    if (push && full && !pop && drop_q != '1) begin
      drop_d = drop_q + 32'd1;
    end
`ifdef RECORD_GAP_TIMEOUT_EN
    resync_d = resync_q;
    if (resync_inc && resync_q != '1) begin
      resync_d = resync_q + 32'd1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rec_q   <= '0;
      stamp_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      drop_q  <= '0;
`ifdef RECORD_GAP_TIMEOUT_EN
      gap_q    <= '0;
      resync_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rec_q   <= rec_d;
      stamp_q <= stamp_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      drop_q  <= drop_d;
`ifdef RECORD_GAP_TIMEOUT_EN
      gap_q    <= gap_d;
      resync_q <= resync_d;
`endif
    end
  end

  // Storage needs no reset: contents are only visible while level_q != 0.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_data_q[wr_q] <= rec_full;
      mem_ts_q[wr_q]   <= stamp_q;
    end
  end

  // Outputs are gated by level, so reset forces them to zero asynchronously.
  // The head entry only changes on a pop, which keeps tdata/tuser stable
  // while a beat is stalled.
  always_comb begin
    m_axis.tvalid = (level_q != '0);
    m_axis.tlast  = m_axis.tvalid;
    m_axis.tdata  = m_axis.tvalid ? mem_data_q[rd_q] : '0;
    m_axis.tuser  = m_axis.tvalid ? mem_ts_q[rd_q] : '0;
  end

  assign drop_count = drop_q;
  assign fifo_level = level_q;
`ifdef RECORD_GAP_TIMEOUT_EN
  assign resync_count = resync_q;
`else
  assign resync_count = '0;
`endif
endmodule

// File: doc/record_ingress_stamper.md
# record_ingress_stamper

Parametrised ingress stage between the UART RX core and `event_record_unpack`. It frames the raw UART byte stream into fixed-size records and stamps each record with the PL timestamp of its first byte. Completed records are buffered in a small FIFO so downstream stages can apply real backpressure. Record loss and framing resyncs are counted so software and ILA can see them.

## Interface
Parameters:
- `RECORD_BYTES`, 32: bytes per record; legal values ≥ 2.
- `FIFO_DEPTH`, 4: record FIFO entries; power of two, ≥ 2.
- `TS_W`, 64: timestamp width.
- `GAP_TIMEOUT`, 1024: idle cycles that abort a partial record; ≥ 1.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `uart_rx_valid` in 1: byte strobe from UART RX; one cycle per byte.
- `uart_rx_data` in 8: received byte.
- `pl_now` in TS_W: free-running PL timestamp from `pl_timestamp_counter`.
- `m_axis_tdata` out RECORD_BYTES*8: record; byte i sits at [8i+7:8i], and the first received byte is byte 0.
- `m_axis_tuser` out TS_W: `pl_now` sampled on the cycle the record's first byte arrived.
- `m_axis_tvalid` out 1: record available.
- `m_axis_tready` in 1: downstream accept.
- `m_axis_tlast` out 1: equals `m_axis_tvalid` (one beat per record).
- `drop_count` out 32: records discarded because the FIFO was full; saturating.
- `resync_count` out 32: partial records aborted by gap timeout; saturating.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: number of stored records.

## Operation
- Framer FSM, two states:
  - IDLE: on `uart_rx_valid`, write the byte to slot 0, capture `pl_now` into the stamp register, set byte_cnt = 1, go to COLLECT.
  - COLLECT: on `uart_rx_valid`, write the byte to slot byte_cnt and increment byte_cnt.
  - When byte_cnt == RECORD_BYTES-1 and a byte arrives, the record is complete: request a FIFO push and return to IDLE.
- Gap timer, active only in COLLECT:
  - Clears on every accepted byte and increments each cycle with no byte.
  - On reaching GAP_TIMEOUT: discard the partial record, increment `resync_count`, return to IDLE.
  - If a byte and the timeout coincide, the byte wins: it is stored and the timer clears.
- Push:
  - Writes the assembled bytes plus stamp as one FIFO entry.
  - If the FIFO is full and no pop occurs that cycle: the record is dropped and `drop_count` increments.
  - If the FIFO is full and a pop occurs the same cycle: the push is accepted and the level is unchanged.
- Pop: occurs on `m_axis_tvalid && m_axis_tready`; read pointers wrap modulo FIFO_DEPTH.
- Output data and tuser are stable while tvalid is high and tready is low (AXI-Stream hold rule).
- Counters saturate at 0xFFFF_FFFF; they never wrap.
- UART bytes are never back-pressured; loss occurs only by whole-record drop.

## Timing
- Reset values:
  - outputs: tvalid = 0, tlast = 0, tdata = 0, tuser = 0, drop_count = 0, resync_count = 0, fifo_level = 0.
  - internal state: FSM in IDLE, byte_cnt = 0, gap timer = 0.
- Latency: last byte sampled on cycle N → `m_axis_tvalid` high on cycle N+1 when the FIFO was empty.
- The stamp is `pl_now` registered on the same edge that samples the first byte. A record's stamp-to-tvalid gap is therefore at least RECORD_BYTES-1 cycles plus 1.
- Throughput: one pop per cycle; back-to-back records are sustained when tready stays high.
- `fifo_level` updates the cycle after a push or pop. A simultaneous push and pop leaves it unchanged.
- Reset asserted mid-record or mid-handshake:
  - clears the partial record and all FIFO contents immediately.
  - tvalid falls asynchronously and no beat is presented.
  - after release, the first byte starts a new record.

## Configuration
- `RECORD_GAP_TIMEOUT_EN` defined:
  - gap timer and resync behaviour are built as above.
- `RECORD_GAP_TIMEOUT_EN` not defined:
  - no gap timer; a partial record waits indefinitely for its remaining bytes.
  - `resync_count` is tied to 0.
  - GAP_TIMEOUT is ignored.

## Test plan
- Single record, RECORD_BYTES=32: send bytes 0x00..0x1F with `pl_now`=1000 at the first byte and tready=1 → one beat with tdata[7:0]=0x00, tdata[255:248]=0x1F, tuser=1000, tlast=1, on the cycle after byte 0x1F.
- Backpressure and overflow, FIFO_DEPTH=4, tready=0: send 6 records → fifo_level=4 and drop_count=2. Then raise tready → exactly 4 beats emerge in order, each carrying its own first-byte stamp.
- Full FIFO with push and pop in the same cycle: with fifo_level=4, complete a 5th record on the same cycle as a pop → record accepted, fifo_level stays 4, drop_count unchanged.
- Gap timeout with GAP_TIMEOUT=16, macro defined: send 10 bytes, idle 16 cycles, then send 32 bytes → resync_count=1 and one record out, whose byte 0 is the first byte after the gap.
- Byte on the timeout cycle: a byte arriving exactly on cycle 16 of the gap is kept → resync_count=0 and the record completes normally.
- Reset mid-record: assert rst_n=0 after 20 bytes with 2 records queued → all outputs 0 and fifo_level=0. After release, 32 new bytes produce exactly one record.
